// File: rtl/memoria_tiros_param.sv
// Parametrised shot-load RAM: write-first port, registered read address,
// clear sweep sequencer, occupancy bitmap with live count and lowest-free-slot finder.
module memoria_tiros_param #(
    parameter int unsigned DATA_W = 2,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              clear,
    output logic [DATA_W-1:0] q,
    output logic              busy,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W-1:0] free_addr,
    output logic              free_valid
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CW    = ADDR_W + 1;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] ram [DEPTH];
    logic [DEPTH-1:0]  occ;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] addr_reg;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              data_nz;
    logic              wr_accept;
    logic              clr_accept;

    assign data_nz    = |data;
    assign clr_accept = (state == IDLE) && clear;
    assign wr_accept  = (state == IDLE) && we && !clear;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (clear) state_next = SWEEP;
            SWEEP:   if (ptr == ADDR_W'(DEPTH - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= SWEEP;
        else       state <= state_next;
    end

    // Single RAM write port shared by the sweep and the user write.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = addr;
        ram_wdata = data;
        if (!reset) begin
            if (state == SWEEP) begin
                ram_we    = 1'b1;
                ram_waddr = ptr;
                ram_wdata = '0;
            end else if (wr_accept) begin
                ram_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            occ      <= '0;
            count    <= '0;
            addr_reg <= '0;
        end else begin
            addr_reg <= addr;
            if (clr_accept) begin
                ptr   <= '0;
                occ   <= '0;
                count <= '0;
            end else if (wr_accept) begin
                // occ[addr] mirrors old ram[addr] != 0, so the count stays in 0..DEPTH.
                occ[addr] <= data_nz;
                count     <= count + CW'(data_nz) - CW'(occ[addr]);
            end else if (state == SWEEP) begin
                ptr <= ptr + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        logic found;
        found     = 1'b0;
        free_addr = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && !occ[i]) begin
                free_addr = ADDR_W'(i);
                found     = 1'b1;
            end
        end
    end

    assign q          = ram[addr_reg];
    assign busy       = (state == SWEEP);
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign free_valid = !full;

endmodule

// File: tb/tb_memoria_tiros_param.sv
// Bench for memoria_tiros_param: two instances (2x16 and 4x8) share one stimulus
// stream and are compared each cycle against an array-based reference model.
module tb_memoria_tiros_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, we, clear;
    logic [3:0] addr, data;

    logic [1:0] q_a;
    logic       busy_a, empty_a, full_a, free_valid_a;
    logic [4:0] count_a;
    logic [3:0] free_addr_a;

    logic [3:0] q_b;
    logic       busy_b, empty_b, full_b, free_valid_b;
    logic [3:0] count_b;
    logic [2:0] free_addr_b;

    memoria_tiros_param #(.DATA_W(2), .ADDR_W(4)) dut_a (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .data(data[1:0]),
        .clear(clear), .q(q_a), .busy(busy_a), .count(count_a), .empty(empty_a),
        .full(full_a), .free_addr(free_addr_a), .free_valid(free_valid_a)
    );

    memoria_tiros_param #(.DATA_W(4), .ADDR_W(3)) dut_b (
        .clk(clk), .reset(reset), .we(we), .addr(addr[2:0]), .data(data),
        .clear(clear), .q(q_b), .busy(busy_b), .count(count_b), .empty(empty_b),
        .full(full_b), .free_addr(free_addr_b), .free_valid(free_valid_b)
    );

    int unsigned mem [2][16];
    int unsigned busy_left [2];
    int unsigned raddr [2];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    function automatic int unsigned depth_of(input int k);
        return (k == 0) ? 16 : 8;
    endfunction

    function automatic int unsigned mask_of(input int k);
        return (k == 0) ? 3 : 15;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int unsigned d;
            d = depth_of(k);
            if (reset) begin
                busy_left[k] = d;
                raddr[k]     = 0;
                for (int i = 0; i < 16; i++) mem[k][i] = 0;
            end else begin
                raddr[k] = addr % d;
                if (busy_left[k] > 0) begin
                    busy_left[k]--;
                end else if (clear) begin
                    busy_left[k] = d;
                    for (int i = 0; i < 16; i++) mem[k][i] = 0;
                end else if (we) begin
                    mem[k][addr % d] = data & mask_of(k);
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            int unsigned d, cnt, fa;
            bit          is_full, is_busy, found;
            d     = depth_of(k);
            cnt   = 0;
            fa    = 0;
            found = 0;
            for (int unsigned i = 0; i < d; i++) begin
                if (mem[k][i] != 0) cnt++;
                else if (!found) begin fa = i; found = 1; end
            end
            is_full = (cnt == d);
            is_busy = (busy_left[k] > 0);
            if (k == 0) begin
                check("a.busy", 32'(busy_a), 32'(is_busy));
                check("a.count", 32'(count_a), cnt);
                check("a.empty", 32'(empty_a), 32'(cnt == 0));
                check("a.full", 32'(full_a), 32'(is_full));
                check("a.free_addr", 32'(free_addr_a), fa);
                check("a.free_valid", 32'(free_valid_a), 32'(!is_full));
                if (!is_busy) check("a.q", 32'(q_a), mem[0][raddr[0]]);
            end else begin
                check("b.busy", 32'(busy_b), 32'(is_busy));
                check("b.count", 32'(count_b), cnt);
                check("b.empty", 32'(empty_b), 32'(cnt == 0));
                check("b.full", 32'(full_b), 32'(is_full));
                check("b.free_addr", 32'(free_addr_b), fa);
                check("b.free_valid", 32'(free_valid_b), 32'(!is_full));
                if (!is_busy) check("b.q", 32'(q_b), mem[1][raddr[1]]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic r, input logic w, input logic c,
                         input logic [3:0] a, input logic [3:0] d);
        reset = r;
        we    = w;
        clear = c;
        addr  = a;
        data  = d;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        repeat (18) step();
        for (int i = 0; i < 16; i++) begin drive(0, 0, 0, 4'(i), 0); step(); end

        // fill every slot with 01
        for (int i = 0; i < 16; i++) begin drive(0, 1, 0, 4'(i), 4'b0001); step(); end
        drive(0, 0, 0, 0, 0); step();

        // free slot 5, then overwrite it twice
        drive(0, 1, 0, 5, 4'b0000); step();
        drive(0, 1, 0, 5, 4'b0011); step();
        drive(0, 1, 0, 5, 4'b0010); step();
        drive(0, 0, 0, 5, 0); step();

        // write-first on slot 7
        drive(0, 1, 0, 7, 4'b0010); step();
        drive(0, 0, 0, 7, 0); step();

        // clear collides with a write, then a write during the sweep
        drive(0, 1, 1, 3, 4'b0011); step();
        drive(0, 1, 0, 4, 4'b0011); step();
        drive(0, 0, 0, 4, 0);
        repeat (16) step();
        drive(0, 0, 0, 3, 0); step();
        drive(0, 0, 0, 4, 0); step();

        // refill partially, then reset in the middle of a sweep
        for (int i = 0; i < 10; i++) begin drive(0, 1, 0, 4'(i), 4'b0110); step(); end
        drive(0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        repeat (5) step();
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        repeat (17) step();
        for (int i = 0; i < 16; i++) begin drive(0, 0, 0, 4'(i), 0); step(); end

        // clear held high: back-to-back sweeps
        drive(0, 1, 1, 2, 4'b0001);
        repeat (40) step();
        drive(0, 0, 0, 0, 0);
        repeat (17) step();

        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 399) == 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 59) == 0), 4'($urandom), 4'($urandom));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/memoria_tiros_param.md
# memoria_tiros_param

Parametrised successor to the fixed 16×2 shot-load RAM in the AstroGenius shot subsystem. It holds one `DATA_W`-bit shot-load entry per slot for `2**ADDR_W` slots, with a write-first port and a registered read address. It adds three things the fixed RAM lacks:
- a hardware clear sequencer for reset and new rounds;
- an occupancy bitmap with a live count of non-zero slots;
- a lowest-free-slot finder, so the shot spawner can allocate slots without scanning memory.

## Interface
- `DATA_W`, default 2: width of each shot-load entry.
- `ADDR_W`, default 4: address width; depth `DEPTH = 2**ADDR_W`.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `reset`  in  1: synchronous, active-high; starts a clear sweep.
- `we`  in  1: write enable, honoured only when `busy`=0.
- `addr`  in  `ADDR_W`: read/write address.
- `data`  in  `DATA_W`: write data.
- `clear`  in  1: single-cycle request to zero all slots, honoured only when `busy`=0.
- `q`  out  `DATA_W`: read data = `ram[addr_reg]`.
- `busy`  out  1: clear sweep in progress.
- `count`  out  `ADDR_W+1`: number of slots holding a non-zero value.
- `empty`  out  1: `count`==0.
- `full`  out  1: `count`==`DEPTH`.
- `free_addr`  out  `ADDR_W`: lowest index whose slot is zero; 0 when `full`.
- `free_valid`  out  1: !`full`.

## Operation
- Storage: `ram[DEPTH]` of `DATA_W` bits.
- Occupancy: flop bitmap `occ[DEPTH]`, where `occ[i]`=1 iff `ram[i]`!=0. `count` is a flop counter, not a popcount.
- FSM has two states: IDLE and SWEEP.
  - IDLE: on `clear`=1, go to SWEEP with `ptr`<=0, `occ`<=0, `count`<=0. `we` in that same cycle is dropped, because clear wins.
  - IDLE with `we`=1 and `clear`=0: `ram[addr]`<=`data`; `occ[addr]`<=(`data`!=0); `count` <= `count` + (`data`!=0) − (old `ram[addr]`!=0).
    - Writing zero frees the slot.
    - Overwriting non-zero with non-zero leaves `count` unchanged.
  - SWEEP: each cycle `ram[ptr]`<=0 and `ptr`<=`ptr`+1. When `ptr`==`DEPTH`−1, return to IDLE. A sweep lasts exactly `DEPTH` cycles.
  - SWEEP: `we` and `clear` are ignored; they are not queued.
- `reset`=1 forces SWEEP with `ptr`<=0, `occ`<=0, `count`<=0, `addr_reg`<=0. This holds for as long as reset is held, and also when reset arrives mid-sweep, which restarts the sweep from slot 0.
- `addr_reg`<=`addr` every cycle outside reset, including during SWEEP.
- `free_addr`: combinational priority encode of lowest `occ` bit equal to 0.
- Arithmetic: `count` never wraps. Its range is 0..`DEPTH`, guaranteed by the bitmap consistency.

## Timing
- Reset values:
  - `busy`=1, `count`=0, `empty`=1, `full`=0, `free_addr`=0, `free_valid`=1.
  - `q`=`ram[0]`, whose content is undefined until the sweep has passed slot 0.
- After `reset` deasserts, `busy` stays 1 for `DEPTH` cycles, then falls. From the `busy` fall onward, `q` reads 0 for any address.
- Read latency: address presented at edge N gives data on `q` after edge N, valid during cycle N+1.
- Write-first: write and read of the same `addr` at edge N means `q` shows the new `data` after edge N.
- `count`, `occ`, `free_addr`, `empty` and `full` reflect a write in the cycle after its edge.
- `clear` sampled at edge N: `busy`=1 and `count`=0 from after edge N, through the edge N+`DEPTH`. `busy`=0 after edge N+`DEPTH`. At that point, the earliest accepted write is at edge N+`DEPTH`+1.
- `clear` held high continuously causes back-to-back sweeps. Each new sweep is accepted on the first IDLE cycle.

## Test plan
1. Reset check (defaults `DATA_W`=2, `ADDR_W`=4):
   - Stimulus: `reset` for 1 cycle, then idle.
   - Required: `busy`=1 for exactly 16 cycles; then `count`=0, `empty`=1, `free_addr`=0, and `q`=0 for `addr`=0..15.
2. Fill and full:
   - Stimulus: write `data`=2'b01 to slots 0..15 in order.
   - Required: `count` steps 1..16; `free_addr` tracks 1..15; after the last write `full`=1, `free_valid`=0, `free_addr`=0.
3. Free and overwrite:
   - Stimulus: from full, write 0 to slot 5, then 2'b11 to slot 5, then 2'b10 to slot 5.
   - Required: `count` goes 15, 16, 16; `free_addr`=5 only after the first write; `q` at slot 5 reads 2'b10.
4. Write-first read:
   - Stimulus: `we`=1, `addr`=7, `data`=2'b10 while slot 7 holds 2'b01.
   - Required: `q`=2'b10 in the next cycle.
5. Clear collisions:
   - Stimulus: `clear` and `we` (`addr`=3, `data`=2'b11) in the same cycle, then `we` to slot 4 during the sweep.
   - Required: neither write lands; `count`=0 throughout; both slots read 0 after `busy` falls 16 cycles later.
6. Reset mid-sweep:
   - Stimulus: `clear`, then `reset` at sweep cycle 6.
   - Required: sweep restarts; `busy` stays 1 for 16 cycles after `reset` deasserts; all slots read 0 afterwards.
   - Rerun with `DATA_W`=4, `ADDR_W`=3: sweep lasts 8 cycles and `full` rises at `count`=8.
